mips_run_ctrl: RTL and testbench

Synthesizable run controller between the bench clock/reset and the multi-cycle MIPS core, replacing fixed-delay reset and stop timing. Holds the core in reset for a programmable number of cycles and counts cycles plus memory reads and writes. Terminates the run either when the core spins on a halt instruction or when a cycle budget expires. Supports restart without a global reset, so one bench can run several programs back to back.

---
 rtl/mips_sim_pkg.sv | 10 +
 rtl/mips_run_ctrl_sat_counter.sv | 18 +
 rtl/mips_run_ctrl.sv | 105 ++++++++++
 tb/tb_mips_run_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_sim_pkg.sv
// mips_sim_pkg: shared run-state encoding and default halt instruction for the MIPS run controller.
package mips_sim_pkg;
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;
    localparam logic [31:0] HALT_INST_DEF = 32'h1000FFFF;
endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear beats enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = clr ? '0 : (en && q_q != '1) ? q_q + 1'b1 : q_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: holds the core in reset, runs it until halt spin or cycle budget, and counts activity.
module mips_run_ctrl
    import mips_sim_pkg::*;
#(
    parameter int          RST_CYCLES = 4,
    parameter int          MAX_CYCLES = 625,
    parameter logic [31:0] HALT_INST  = HALT_INST_DEF,
    parameter int          HALT_HOLD  = 16,
    parameter int          AW         = 32,
    parameter int          CW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic [31:0]   inst,
    input  logic [AW-1:0] mem_adr,
    input  logic          mem_read,
    input  logic          mem_write,
    output logic          cpu_rst,
    output logic          running,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic [AW-1:0] last_wr_adr
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(HALT_HOLD + 1);
    run_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [LW-1:0] halt_q, halt_d;
    logic          cpu_rst_q, cpu_rst_d, running_q, running_d;
    logic          done_q, done_d, timeout_q, timeout_d;
    logic [AW-1:0] last_q, last_d;
    logic          run, match, budget_end;
    assign run   = state_q == ST_RUN;
    assign match = inst == HALT_INST;
    // widened compare so a narrow counter that saturates below the budget never aliases it
    assign budget_end = 64'(cycle_cnt) == 64'(MAX_CYCLES - 1);
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        halt_d    = halt_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        last_d    = last_q;
        if (restart) begin
            state_d   = ST_HOLD;
            hold_d    = '0;
            halt_d    = '0;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            last_d    = '0;
        end else if (state_q == ST_HOLD) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(RST_CYCLES - 1)) begin
                state_d   = ST_RUN;
                cpu_rst_d = 1'b0;
            end
        end else if (run) begin
            halt_d = match ? halt_q + 1'b1 : '0;
            last_d = mem_write ? mem_adr : last_q;
            if (match && halt_q == LW'(HALT_HOLD - 1)) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
            end else if (budget_end) begin
                state_d   = ST_TIMEOUT;
                timeout_d = 1'b1;
            end
        end
        running_d = state_d == ST_RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            halt_q    <= '0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            halt_q    <= halt_d;
            cpu_rst_q <= cpu_rst_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
        end
    end
    sat_counter #(.W(CW)) u_cyc (.clk(clk), .rst(rst), .clr(restart), .en(run), .q(cycle_cnt));
    sat_counter #(.W(CW)) u_rd (.clk(clk), .rst(rst), .clr(restart), .en(run && mem_read), .q(rd_cnt));
    sat_counter #(.W(CW)) u_wr (.clk(clk), .rst(rst), .clr(restart), .en(run && mem_write), .q(wr_cnt));
    assign cpu_rst     = cpu_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign last_wr_adr = last_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: vector table plus randomized runs against a cycle-level reference model, default and 4-bit counters.
module tb_mips_run_ctrl;
    localparam int          RST  = 4;
    localparam int          MAXC = 625;
    localparam int          HH   = 16;
    localparam logic [31:0] HALT = 32'h1000FFFF;

    logic        clk = 1'b0, rst = 1'b1, restart = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] inst = '0, mem_adr = '0;
    logic        cpu_rst, running, done, timeout;
    logic [31:0] cycle_cnt, rd_cnt, wr_cnt, last_wr_adr;
    logic        cpu_rst4, running4, done4, timeout4;
    logic [3:0]  cycle_cnt4, rd_cnt4, wr_cnt4;
    logic [31:0] last_wr_adr4;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mips_run_ctrl dut (
        .clk(clk), .rst(rst), .restart(restart), .inst(inst), .mem_adr(mem_adr),
        .mem_read(mem_read), .mem_write(mem_write), .cpu_rst(cpu_rst), .running(running),
        .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt), .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt), .last_wr_adr(last_wr_adr)
    );

    mips_run_ctrl #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .restart(restart), .inst(inst), .mem_adr(mem_adr),
        .mem_read(mem_read), .mem_write(mem_write), .cpu_rst(cpu_rst4), .running(running4),
        .done(done4), .timeout(timeout4), .cycle_cnt(cycle_cnt4), .rd_cnt(rd_cnt4),
        .wr_cnt(wr_cnt4), .last_wr_adr(last_wr_adr4)
    );

    // reference: cycles of reset left, run/terminal flags, saturated tallies, halt streak
    typedef struct {
        int          hold_left;
        bit          run, fin, to;
        longint      cyc, rd, wr, streak;
        logic [31:0] adr;
    } mdl_t;

    mdl_t m, m4;

    function automatic mdl_t fresh();
        mdl_t n;
        n.hold_left = RST;
        n.run = 0; n.fin = 0; n.to = 0;
        n.cyc = 0; n.rd = 0; n.wr = 0; n.streak = 0;
        n.adr = '0;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m0, input bit rs, input logic [31:0] in,
                                  input bit r, input bit w, input logic [31:0] a, input int cw);
        mdl_t   n = m0;
        longint lim = (longint'(1) << cw) - 1;
        if (rs) return fresh();
        if (m0.hold_left > 0) begin
            n.hold_left = m0.hold_left - 1;
            n.run = (n.hold_left == 0);
            return n;
        end
        if (!m0.run) return n;
        n.cyc = (m0.cyc < lim) ? m0.cyc + 1 : lim;
        if (r) n.rd = (m0.rd < lim) ? m0.rd + 1 : lim;
        if (w) begin
            n.wr  = (m0.wr < lim) ? m0.wr + 1 : lim;
            n.adr = a;
        end
        n.streak = (in == HALT) ? m0.streak + 1 : 0;
        if (n.streak >= HH) begin
            n.run = 0; n.fin = 1;
        end else if (n.cyc == MAXC) begin
            n.run = 0; n.to = 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("cpu_rst", cpu_rst, m.hold_left > 0);
        chk("running", running, m.run);
        chk("done", done, m.fin);
        chk("timeout", timeout, m.to);
        chk("cycle_cnt", cycle_cnt, m.cyc);
        chk("rd_cnt", rd_cnt, m.rd);
        chk("wr_cnt", wr_cnt, m.wr);
        chk("last_wr_adr", last_wr_adr, m.adr);
        chk("cpu_rst4", cpu_rst4, m4.hold_left > 0);
        chk("running4", running4, m4.run);
        chk("done4", done4, m4.fin);
        chk("timeout4", timeout4, m4.to);
        chk("cycle_cnt4", cycle_cnt4, m4.cyc);
        chk("rd_cnt4", rd_cnt4, m4.rd);
        chk("wr_cnt4", wr_cnt4, m4.wr);
        chk("last_wr_adr4", last_wr_adr4, m4.adr);
    endtask

    task automatic cycle(input bit rs, input logic [31:0] in, input bit r, input bit w, input logic [31:0] a);
        restart = rs; inst = in; mem_read = r; mem_write = w; mem_adr = a;
        @(posedge clk);
        m  = step(m, rs, in, r, w, a, 32);
        m4 = step(m4, rs, in, r, w, a, 4);
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_cycle(input bit allow_halt);
        logic [31:0] in = allow_halt && ($urandom_range(0, 2) == 0) ? HALT : ($urandom & 32'hFFFF_0000);
        cycle(0, in, 1'($urandom), 1'($urandom), $urandom & 32'hFFFC);
    endtask

    typedef struct {
        bit          r, w;
        logic [31:0] adr;
        bit          e_cr, e_run;
        int          e_cyc, e_rd, e_wr;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rd_save;
        vecs[0]  = '{0, 0, 32'h00, 1, 0, 0, 0, 0, 32'h00};
        vecs[1]  = '{1, 1, 32'h99, 1, 0, 0, 0, 0, 32'h00};
        vecs[2]  = '{0, 0, 32'h00, 1, 0, 0, 0, 0, 32'h00};
        vecs[3]  = '{0, 0, 32'h00, 0, 1, 0, 0, 0, 32'h00};
        vecs[4]  = '{1, 0, 32'h10, 0, 1, 1, 1, 0, 32'h00};
        vecs[5]  = '{1, 0, 32'h14, 0, 1, 2, 2, 0, 32'h00};
        vecs[6]  = '{0, 1, 32'h20, 0, 1, 3, 2, 1, 32'h20};
        vecs[7]  = '{1, 0, 32'h18, 0, 1, 4, 3, 1, 32'h20};
        vecs[8]  = '{0, 1, 32'h24, 0, 1, 5, 3, 2, 32'h24};
        vecs[9]  = '{1, 1, 32'h28, 0, 1, 6, 4, 3, 32'h28};
        vecs[10] = '{0, 0, 32'h00, 0, 1, 7, 4, 3, 32'h28};
        m = fresh(); m4 = fresh();
        repeat (5) @(negedge clk);
        check_all();
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cycle(0, 32'h0, vecs[i].r, vecs[i].w, vecs[i].adr);
            chk("vec cpu_rst", cpu_rst, vecs[i].e_cr);
            chk("vec running", running, vecs[i].e_run);
            chk("vec cycle_cnt", cycle_cnt, vecs[i].e_cyc);
            chk("vec rd_cnt", rd_cnt, vecs[i].e_rd);
            chk("vec wr_cnt", wr_cnt, vecs[i].e_wr);
            chk("vec last_wr_adr", last_wr_adr, vecs[i].e_adr);
        end
        // halt: an interrupted burst of 15 must not count
        repeat (15) cycle(0, HALT, 0, 0, 0);
        chk("halt early done", done, 0);
        cycle(0, 32'h0, 0, 0, 0);
        repeat (15) cycle(0, HALT, 0, 0, 0);
        chk("halt 15 done", done, 0);
        cycle(0, HALT, 0, 0, 0);
        chk("halt done", done, 1);
        chk("halt running", running, 0);
        chk("halt timeout", timeout, 0);
        chk("halt cycle_cnt", cycle_cnt, 39);
        repeat (5) rnd_cycle(1);
        chk("halt frozen cycle_cnt", cycle_cnt, 39);
        chk("halt frozen rd_cnt", rd_cnt, 4);
        // restart from a terminal state, then timeout on budget
        cycle(1, 32'h0, 0, 0, 0);
        chk("restart cpu_rst", cpu_rst, 1);
        chk("restart done", done, 0);
        chk("restart cycle_cnt", cycle_cnt, 0);
        repeat (RST) cycle(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < MAXC; i++) begin
            cycle(0, (i % 20 < 8) ? HALT : ($urandom & 32'hFFFF_0000), 1'($urandom), 1'($urandom), $urandom & 32'hFFFC);
        end
        chk("to timeout", timeout, 1);
        chk("to done", done, 0);
        chk("to cycle_cnt", cycle_cnt, MAXC);
        chk("to running4", running4, 1);
        chk("to cycle_cnt4", cycle_cnt4, 15);
        rd_save = rd_cnt;
        repeat (10) rnd_cycle(0);
        chk("to held cycle_cnt", cycle_cnt, MAXC);
        chk("to held rd_cnt", rd_cnt, rd_save);
        // halt completes on the last budget cycle: halt wins
        cycle(1, 32'h0, 0, 0, 0);
        repeat (RST) cycle(0, 32'h0, 0, 0, 0);
        repeat (MAXC - HH) rnd_cycle(0);
        repeat (HH - 1) cycle(0, HALT, 0, 0, 0);
        chk("sim pre done", done, 0);
        chk("sim pre cycle_cnt", cycle_cnt, MAXC - 1);
        cycle(0, HALT, 0, 0, 0);
        chk("sim done", done, 1);
        chk("sim timeout", timeout, 0);
        chk("sim cycle_cnt", cycle_cnt, MAXC);
        // restart mid-run at cycle 100, with a restart inside HOLD as well
        cycle(1, 32'h0, 0, 0, 0);
        repeat (2) cycle(0, 32'h0, 0, 0, 0);
        cycle(1, 32'h0, 1, 1, 32'h40);
        repeat (RST) cycle(0, 32'h0, 0, 0, 0);
        repeat (100) rnd_cycle(1);
        chk("mid cycle_cnt", cycle_cnt, 100);
        chk("mid cycle_cnt4", cycle_cnt4, 15);
        cycle(1, 32'h0, 1, 1, 32'h44);
        chk("mid cpu_rst", cpu_rst, 1);
        chk("mid running", running, 0);
        chk("mid cycle_cnt clr", cycle_cnt, 0);
        chk("mid rd_cnt clr", rd_cnt, 0);
        chk("mid wr_cnt clr", wr_cnt, 0);
        chk("mid last_wr_adr clr", last_wr_adr, 0);
        for (int i = 0; i < RST - 1; i++) begin
            cycle(0, 32'h0, 0, 0, 0);
            chk("mid hold cpu_rst", cpu_rst, 1);
        end
        cycle(0, 32'h0, 0, 0, 0);
        chk("mid release cpu_rst", cpu_rst, 0);
        chk("mid release running", running, 1);
        repeat (20) rnd_cycle(1);
        // asynchronous reset mid-cycle takes effect without an edge
        #2 rst = 1'b1;
        #1;
        chk("arst cpu_rst", cpu_rst, 1);
        chk("arst running", running, 0);
        chk("arst cycle_cnt", cycle_cnt, 0);
        chk("arst wr_cnt", wr_cnt, 0);
        chk("arst last_wr_adr", last_wr_adr, 0);
        m = fresh(); m4 = fresh();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        repeat (10) rnd_cycle(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
